// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution filter engine.
// Holds the state encoding, a ceil-log2 helper and the signed saturation bounds.
package conv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MAC   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         r++;
      end
      return r;
   endfunction

   function automatic longint sat_max(input int width);
      return (64'sd1 <<< (width - 1)) - 64'sd1;
   endfunction

   function automatic longint sat_min(input int width);
      return -(64'sd1 <<< (width - 1));
   endfunction

endpackage

// File: rtl/conv_filter_engine_if.sv
// Streaming pair input and result output of the convolution filter engine.
// The master drives pairs and accepts results; the slave is the engine.
interface conv_filter_engine_if #(
   parameter int BITWIDTH = 8
) ();

   logic                           in_valid;
   logic                           in_ready;
   logic signed [BITWIDTH-1:0]     weight;
   logic signed [BITWIDTH-1:0]     data;
   logic signed [2*BITWIDTH-1:0]   bias;
   logic                           relu_en;
   logic                           out_valid;
   logic                           out_ready;
   logic signed [2*BITWIDTH-1:0]   result;

   modport master (
      output in_valid, weight, data, bias, relu_en, out_ready,
      input  in_ready, out_valid, result
   );

   modport slave (
      input  in_valid, weight, data, bias, relu_en, out_ready,
      output in_ready, out_valid, result
   );

endinterface

// File: rtl/conv_filter_engine_mac_pipe.sv
// Two-stage multiply-accumulate: registered full-precision product, then
// sign-extended accumulation seeded by the first product of each window.
module mac_pipe
   import conv_pkg::*;
#(
   parameter int BITWIDTH  = 8,
   parameter int ACC_WIDTH = 24
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        clear,
   input  logic                        in_fire,
   input  logic                        in_first,
   input  logic signed [BITWIDTH-1:0]  weight,
   input  logic signed [BITWIDTH-1:0]  data,
   output logic signed [ACC_WIDTH-1:0] acc
);

   localparam int PROD_W = 2 * BITWIDTH;

   logic signed [PROD_W-1:0]    prod_next;
   logic signed [PROD_W-1:0]    prod_q;
   logic                        prod_valid_q;
   logic                        prod_first_q;
   logic signed [ACC_WIDTH-1:0] prod_ext;

   assign prod_next = weight * data;
   assign prod_ext  = {{(ACC_WIDTH-PROD_W){prod_q[PROD_W-1]}}, prod_q};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prod_q       <= '0;
         prod_valid_q <= 1'b0;
         prod_first_q <= 1'b0;
         acc          <= '0;
      end else if (clear) begin
         prod_valid_q <= 1'b0;
         prod_first_q <= 1'b0;
      end else begin
         prod_valid_q <= in_fire;
         prod_first_q <= in_first;
         if (in_fire) begin
            prod_q <= prod_next;
         end
         // Seeding from the first product avoids carrying the previous window's sum.
         if (prod_valid_q) begin
            acc <= prod_first_q ? prod_ext : acc + prod_ext;
         end
      end
   end

endmodule

// File: rtl/conv_filter_engine.sv
// Convolution filter engine: counts one window of weight/data pairs through the
// MAC pipeline, then adds bias, saturates, applies optional ReLU and holds the result.
//
// state    | meaning
// ST_IDLE  | waiting for the first pair of a window
// ST_MAC   | accepting the remaining pairs of the window
// ST_DRAIN | two cycles letting the MAC pipeline settle
// ST_HOLD  | result presented until the downstream handshake
module conv_filter_engine
   import conv_pkg::*;
#(
   parameter int FILTER_WIDTH   = 5,
   parameter int FILTER_HEIGHT  = 5,
   parameter int FILTER_CHANNEL = 3,
   parameter int BITWIDTH       = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   output logic             busy,
   conv_filter_engine_if.slave bus
);

   localparam int N         = FILTER_WIDTH * FILTER_HEIGHT * FILTER_CHANNEL;
   localparam int RES_W     = 2 * BITWIDTH;
   localparam int ACC_WIDTH = RES_W + clog2(N) + 1;
   localparam int SUM_W     = ACC_WIDTH + 1;
   localparam int CNT_W     = clog2(N + 1);

   localparam logic signed [SUM_W-1:0] SAT_HI   = SUM_W'(sat_max(RES_W));
   localparam logic signed [SUM_W-1:0] SAT_LO   = SUM_W'(sat_min(RES_W));
   localparam logic [CNT_W-1:0]        LAST_CNT = CNT_W'(N - 1);

   state_t                    state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic                      drain_q, drain_d;
   logic signed [RES_W-1:0]   bias_q;
   logic                      relu_q;
   logic signed [RES_W-1:0]   result_q;
   logic                      out_valid_q;

   logic                      in_ready;
   logic                      accept;
   logic                      handshake;
   logic                      first_pair;
   logic                      load_result;

   logic signed [ACC_WIDTH-1:0] acc;
   logic signed [SUM_W-1:0]     sum;
   logic signed [RES_W-1:0]     sat_val;
   logic signed [RES_W-1:0]     final_val;

   assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_MAC);
   assign accept    = bus.in_valid && in_ready && !clear;
   assign handshake = out_valid_q && bus.out_ready && !clear;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      drain_d     = 1'b0;
      first_pair  = 1'b0;
      load_result = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               first_pair = 1'b1;
               if (N == 1) begin
                  cnt_d   = '0;
                  state_d = ST_DRAIN;
               end else begin
                  cnt_d   = CNT_W'(1);
                  state_d = ST_MAC;
               end
            end
         end
         ST_MAC: begin
            if (accept) begin
               if (cnt_q == LAST_CNT) begin
                  cnt_d   = '0;
                  state_d = ST_DRAIN;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_DRAIN: begin
            if (drain_q) begin
               load_result = 1'b1;
               state_d     = ST_HOLD;
            end else begin
               drain_d = 1'b1;
            end
         end
         ST_HOLD: begin
            if (handshake) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (clear) begin
         state_d     = ST_IDLE;
         cnt_d       = '0;
         drain_d     = 1'b0;
         load_result = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         drain_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         drain_q <= drain_d;
      end
   end

   mac_pipe #(
      .BITWIDTH  (BITWIDTH),
      .ACC_WIDTH (ACC_WIDTH)
   ) u_mac_pipe (
      .clk      (clk),
      .reset    (reset),
      .clear    (clear),
      .in_fire  (accept),
      .in_first (first_pair),
      .weight   (bus.weight),
      .data     (bus.data),
      .acc      (acc)
   );

   // One extra bit over the accumulator keeps acc + bias from wrapping before the clamp.
   assign sum = $signed({acc[ACC_WIDTH-1], acc})
              + $signed({{(SUM_W-RES_W){bias_q[RES_W-1]}}, bias_q});

   always_comb begin
      sat_val = sum[RES_W-1:0];
      if (sum > SAT_HI) begin
         sat_val = SAT_HI[RES_W-1:0];
      end else if (sum < SAT_LO) begin
         sat_val = SAT_LO[RES_W-1:0];
      end
      final_val = sat_val;
      if (relu_q && sat_val[RES_W-1]) begin
         final_val = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bias_q      <= '0;
         relu_q      <= 1'b0;
         result_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         if (first_pair) begin
            bias_q <= bus.bias;
            relu_q <= bus.relu_en;
         end
         if (load_result) begin
            result_q <= final_val;
         end
         if (clear) begin
            out_valid_q <= 1'b0;
         end else if (load_result) begin
            out_valid_q <= 1'b1;
         end else if (handshake) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_conv_filter_engine.sv
// Scoreboard bench for conv_filter_engine: a behavioural model queues the expected
// result of each full window, and the queue is popped when the engine presents it.
module tb_conv_filter_engine;

   localparam int N = 75;

   logic clk;
   logic reset;
   logic clear;
   logic busy;

   int n_tests;
   int n_fail;
   longint sb[$];

   conv_filter_engine_if #(.BITWIDTH(8)) bus ();

   conv_filter_engine #(
      .FILTER_WIDTH   (5),
      .FILTER_HEIGHT  (5),
      .FILTER_CHANNEL (3),
      .BITWIDTH       (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .busy  (busy),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input longint obs, input longint exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives np pairs; a full window pushes its modelled result to the scoreboard.
   task automatic send_window(input int np, input bit rnd,
                              input logic signed [7:0] w_fix,
                              input logic signed [7:0] d_fix,
                              input logic signed [15:0] b,
                              input bit relu, input bit gaps);
      longint sum;
      longint exp;
      logic signed [7:0] w;
      logic signed [7:0] d;
      sum = 0;
      for (int i = 0; i < np; i++) begin
         if (gaps && i > 0 && $urandom_range(0, 2) == 0) begin
            bus.in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
         end
         w = rnd ? 8'($urandom_range(0, 255)) : w_fix;
         d = rnd ? 8'($urandom_range(0, 255)) : d_fix;
         bus.in_valid = 1'b1;
         bus.weight   = w;
         bus.data     = d;
         if (i == 0) begin
            bus.bias    = b;
            bus.relu_en = relu;
         end else begin
            bus.bias    = 16'($urandom);
            bus.relu_en = ~relu;
         end
         sum += longint'(w) * longint'(d);
         if (!bus.in_ready) check("in_ready_during_window", bus.in_ready, 1);
         tick();
      end
      bus.in_valid = 1'b0;
      if (np == N) begin
         exp = sum + longint'(b);
         if (exp > 32767) exp = 32767;
         if (exp < -32768) exp = -32768;
         if (relu && exp < 0) exp = 0;
         sb.push_back(exp);
      end
   endtask

   // Called one step after the edge that accepted the last pair (E0).
   task automatic collect(input int hold);
      longint exp;
      longint held;
      check("valid_at_e0", bus.out_valid, 0);
      tick();
      check("valid_at_e1", bus.out_valid, 0);
      tick();
      check("valid_at_e2", bus.out_valid, 1);
      check("in_ready_hold", bus.in_ready, 0);
      check("busy_hold", busy, 1);
      held = bus.result;
      for (int k = 0; k < hold; k++) begin
         tick();
         check("hold_result_stable", bus.result, held);
         check("hold_valid_stable", bus.out_valid, 1);
         check("hold_in_ready", bus.in_ready, 0);
      end
      if (sb.size() == 0) begin
         check("scoreboard_nonempty", 0, 1);
      end else begin
         exp = sb.pop_front();
         check("result", bus.result, exp);
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("valid_after_handshake", bus.out_valid, 0);
      check("busy_after_handshake", busy, 0);
      check("in_ready_after_handshake", bus.in_ready, 1);
   endtask

   initial begin
      n_tests       = 0;
      n_fail        = 0;
      reset         = 1'b0;
      clear         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.weight    = '0;
      bus.data      = '0;
      bus.bias      = '0;
      bus.relu_en   = 1'b0;
      bus.out_ready = 1'b0;
      repeat (2) tick();
      check("reset_busy", busy, 0);
      check("reset_out_valid", bus.out_valid, 0);
      check("reset_result", bus.result, 0);
      check("reset_in_ready", bus.in_ready, 1);
      reset = 1'b1;
      tick();

      send_window(N, 0, 8'sd1, 8'sd1, 16'sd0, 0, 0);
      collect(0);
      send_window(N, 0, 8'sd2, 8'sd3, -16'sd100, 0, 0);
      collect(10);
      send_window(N, 0, 8'sd2, 8'sd3, -16'sd100, 0, 1);
      collect(0);
      send_window(N, 0, -8'sd128, -8'sd128, 16'sd0, 0, 0);
      collect(0);
      send_window(N, 0, 8'sd127, -8'sd128, 16'sd0, 0, 0);
      collect(0);
      send_window(N, 0, 8'sd127, -8'sd128, 16'sd0, 1, 1);
      collect(0);
      for (int r = 0; r < 3; r++) begin
         send_window(N, 1, 8'sd0, 8'sd0, 16'($urandom), 1'($urandom), 1);
         collect(2);
      end

      // Abort by clear, with a pair offered on the same edge.
      send_window(30, 0, 8'sd1, 8'sd1, 16'sd0, 0, 0);
      check("busy_mid_window", busy, 1);
      clear        = 1'b1;
      bus.in_valid = 1'b1;
      bus.weight   = 8'sd5;
      bus.data     = 8'sd5;
      tick();
      clear        = 1'b0;
      bus.in_valid = 1'b0;
      check("clear_busy", busy, 0);
      check("clear_in_ready", bus.in_ready, 1);
      check("clear_out_valid", bus.out_valid, 0);
      send_window(N, 0, 8'sd1, 8'sd1, 16'sd0, 0, 0);
      collect(0);

      // Abort by asynchronous reset mid-window.
      send_window(30, 0, 8'sd3, 8'sd3, 16'sd0, 0, 0);
      #2;
      reset = 1'b0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_result", bus.result, 0);
      tick();
      reset = 1'b1;
      tick();
      check("rst_in_ready", bus.in_ready, 1);
      send_window(N, 0, 8'sd1, 8'sd1, 16'sd0, 0, 1);
      collect(0);

      check("scoreboard_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
